// File: rtl/hasti_slave_demux_if.sv
// AHB-Lite slave-side bundle shared by the upstream port and the per-slave ports.
// hresp is the single-bit AHB-Lite response: 0 = OKAY, 1 = ERROR.
interface if_hasti_slave_io;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic        hready;
    logic        hsel;
    logic        hreadyout;
    logic [31:0] hrdata;
    logic        hresp;

    modport slave (
        input  haddr, hwrite, hsize, hburst, hprot, htrans,
        input  hmastlock, hwdata, hready, hsel,
        output hreadyout, hrdata, hresp
    );

    modport master (
        output haddr, hwrite, hsize, hburst, hprot, htrans,
        output hmastlock, hwdata, hready, hsel,
        input  hreadyout, hrdata, hresp
    );
endinterface

// File: rtl/hasti_slave_demux.sv
// One-to-three AHB-Lite slave demux with a built-in two-cycle ERROR default slave.
// Address phase is broadcast combinationally; the data-phase mux follows a registered select.
module hasti_slave_demux #(
    parameter logic [31:0] BASE0 = 32'h0000_0000,
    parameter logic [31:0] BASE1 = 32'h1000_0000,
    parameter logic [31:0] BASE2 = 32'h2000_0000,
    parameter logic [31:0] MASK  = 32'hF000_0000
) (
    input  logic                    hclk,
    input  logic                    hreset,
    if_hasti_slave_io.slave         in,
    if_hasti_slave_io.master        out0,
    if_hasti_slave_io.master        out1,
    if_hasti_slave_io.master        out2,
    output logic [7:0]              err_count
);

    typedef enum logic [2:0] {
        D_NONE, D_S0, D_S1, D_S2, D_DEF
    } dsel_e;

    typedef enum logic [1:0] {
        DS_IDLE, DS_ERR1, DS_ERR2
    } ds_e;

    dsel_e      dec;
    dsel_e      dsel_q, dsel_d;
    ds_e        ds_q, ds_d;
    logic [7:0] err_q, err_d;
    logic       m0, m1, m2;
    logic       active;
    logic       load_def;

    assign m0 = (in.haddr & MASK) == (BASE0 & MASK);
    assign m1 = (in.haddr & MASK) == (BASE1 & MASK);
    assign m2 = (in.haddr & MASK) == (BASE2 & MASK);

    // Lowest slave index wins when address windows overlap.
    always_comb begin
        dec = D_NONE;
        if (in.hsel) begin
            if (m0)      dec = D_S0;
            else if (m1) dec = D_S1;
            else if (m2) dec = D_S2;
            else         dec = D_DEF;
        end
    end

    assign active   = in.hsel && in.htrans[1];
    assign load_def = in.hready && active && (dec == D_DEF);

    assign out0.hsel      = dec == D_S0;
    assign out0.haddr     = in.haddr;
    assign out0.hwrite    = in.hwrite;
    assign out0.hsize     = in.hsize;
    assign out0.hburst    = in.hburst;
    assign out0.hprot     = in.hprot;
    assign out0.htrans    = in.htrans;
    assign out0.hmastlock = in.hmastlock;
    assign out0.hwdata    = in.hwdata;
    assign out0.hready    = in.hready;

    assign out1.hsel      = dec == D_S1;
    assign out1.haddr     = in.haddr;
    assign out1.hwrite    = in.hwrite;
    assign out1.hsize     = in.hsize;
    assign out1.hburst    = in.hburst;
    assign out1.hprot     = in.hprot;
    assign out1.htrans    = in.htrans;
    assign out1.hmastlock = in.hmastlock;
    assign out1.hwdata    = in.hwdata;
    assign out1.hready    = in.hready;

    assign out2.hsel      = dec == D_S2;
    assign out2.haddr     = in.haddr;
    assign out2.hwrite    = in.hwrite;
    assign out2.hsize     = in.hsize;
    assign out2.hburst    = in.hburst;
    assign out2.hprot     = in.hprot;
    assign out2.htrans    = in.htrans;
    assign out2.hmastlock = in.hmastlock;
    assign out2.hwdata    = in.hwdata;
    assign out2.hready    = in.hready;

    always_comb begin
        dsel_d = dsel_q;
        if (in.hready) begin
            dsel_d = active ? dec : D_NONE;
        end
    end

    always_comb begin
        ds_d = ds_q;
        unique case (ds_q)
            DS_IDLE: if (load_def) ds_d = DS_ERR1;
            DS_ERR1: ds_d = DS_ERR2;
            DS_ERR2: ds_d = load_def ? DS_ERR1 : DS_IDLE;
            default: ds_d = DS_IDLE;
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (ds_d == DS_ERR1 && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            dsel_q <= D_NONE;
            ds_q   <= DS_IDLE;
            err_q  <= 8'h00;
        end else begin
            dsel_q <= dsel_d;
            ds_q   <= ds_d;
            err_q  <= err_d;
        end
    end

    assign err_count = err_q;

    // Response path is purely combinational from the selected slave.
    always_comb begin
        in.hreadyout = 1'b1;
        in.hrdata    = 32'h0;
        in.hresp     = 1'b0;
        unique case (dsel_q)
            D_S0: begin
                in.hreadyout = out0.hreadyout;
                in.hrdata    = out0.hrdata;
                in.hresp     = out0.hresp;
            end
            D_S1: begin
                in.hreadyout = out1.hreadyout;
                in.hrdata    = out1.hrdata;
                in.hresp     = out1.hresp;
            end
            D_S2: begin
                in.hreadyout = out2.hreadyout;
                in.hrdata    = out2.hrdata;
                in.hresp     = out2.hresp;
            end
            D_DEF: begin
                in.hreadyout = ds_q != DS_ERR1;
                in.hresp     = ds_q != DS_IDLE;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/hasti_slave_demux.md
HASTI_SLAVE_DEMUX -- requirements
Module: hasti_slave_demux

Interface
REQ-001 SHALL have parameter BASE0, default 32'h0000_0000, base address of slave 0.
REQ-002 SHALL have parameter BASE1, default 32'h1000_0000, base address of slave 1.
REQ-003 SHALL have parameter BASE2, default 32'h2000_0000, base address of slave 2.
REQ-004 SHALL have parameter MASK, default 32'hF000_0000, decode mask applied to haddr for all slaves.
REQ-005 SHALL have port hclk, input, 1, bus clock; all state updates on its rising edge.
REQ-006 SHALL have port hreset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port in, if_hasti_slave_io slave-side modport, -, upstream master port.
REQ-008 SHALL have port out0, if_hasti_slave_io master-side modport, -, slave 0 port.
REQ-009 SHALL have port out1, if_hasti_slave_io master-side modport, -, slave 1 port.
REQ-010 SHALL have port out2, if_hasti_slave_io master-side modport, -, slave 2 port.
REQ-011 SHALL have port err_count, output, 8, number of ERROR responses issued, saturating.

Function
REQ-012 SHALL mark slave k matched when in.hsel=1 and (in.haddr & MASK)==(BASEk & MASK).
REQ-013 SHALL resolve overlapping matches by priority: lowest k wins.
REQ-014 SHALL treat in.hsel=1 with no match as a default-slave selection.
REQ-015 SHALL drive outK.hsel combinationally: in.hsel AND (slave k is the selected slave).
REQ-016 SHALL broadcast haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata and hready from in to all outK unchanged.
REQ-017 SHALL hold a data-phase select register dsel in {NONE, S0, S1, S2, DEF}.
REQ-018 SHALL load dsel on a rising edge with in.hready=1: the decoded slave if in.hsel=1 and htrans is NONSEQ or SEQ, else NONE.
REQ-019 SHALL hold dsel while in.hready=0.
REQ-020 SHALL drive in.hreadyout, in.hrdata and in.hresp from outK when dsel=Sk, with zero added latency.
REQ-021 SHALL drive in.hreadyout=1, in.hresp=OKAY and in.hrdata=0 when dsel=NONE.
REQ-022 SHALL implement the default slave as FSM DS_IDLE, DS_ERR1, DS_ERR2.
REQ-023 SHALL transition DS_IDLE->DS_ERR1 when an access loads dsel=DEF.
REQ-024 SHALL transition DS_ERR1->DS_ERR2 unconditionally.
REQ-025 SHALL transition from DS_ERR2 to DS_ERR1 if another default-slave access is loaded that cycle, else to DS_IDLE.
REQ-026 SHALL drive in.hreadyout=0 and in.hresp=ERROR in DS_ERR1.
REQ-027 SHALL drive in.hreadyout=1 and in.hresp=ERROR in DS_ERR2.
REQ-028 SHALL drive in.hrdata=0 in both DS_ERR1 and DS_ERR2.
REQ-029 SHALL give IDLE/BUSY transfers to an unmapped address a zero-wait OKAY response, with no FSM change.
REQ-030 SHALL increment err_count by 1 on each entry to DS_ERR1 and SHALL saturate it at 8'hFF.
REQ-031 SHALL, on a back-to-back access to a different slave, switch the response mux only after the current data phase completes (in.hready=1).

Reset
REQ-032 SHALL, while hreset=1 at a rising edge, set dsel=NONE, FSM=DS_IDLE and err_count=0.
REQ-033 SHALL drive in.hreadyout=1 and in.hresp=OKAY in the cycle after reset.
REQ-034 SHALL abandon any transfer in progress when reset is asserted mid-transfer, including DS_ERR1.
REQ-035 SHALL keep the address-phase outputs combinational from in during reset.

Verification
REQ-036 SHALL cover: read haddr=32'h1000_0004 NONSEQ, out1 returns hrdata=32'hCAFE_0001 -> out1.hsel=1 in the address phase; in.hrdata=32'hCAFE_0001 with hreadyout=1 in the next cycle; out0.hsel=out2.hsel=0.
REQ-037 SHALL cover: write to 32'h2000_0000 with out2 inserting 2 wait states, then a NONSEQ to 32'h0000_0010 -> in.hreadyout=0 for 2 cycles; dsel stays S2 throughout; out0 data phase starts only afterwards.
REQ-038 SHALL cover: NONSEQ to 32'h5000_0000 -> ERROR with hreadyout=0, then ERROR with hreadyout=1; err_count=1; all outK.hsel=0.
REQ-039 SHALL cover: IDLE transfer with hsel=1 to 32'h5000_0000 -> OKAY, zero wait, err_count unchanged.
REQ-040 SHALL cover: 300 unmapped accesses -> err_count saturates at 8'hFF.
REQ-041 SHALL cover: hreset asserted in DS_ERR1 -> next cycle in.hreadyout=1, in.hresp=OKAY, err_count=0.
